// File: rtl/keygen_pkg.sv
// keygen_pkg
// Shared definitions for the key-generation sequencer:
//   keygen_state_e   - sequencer FSM states
//   OUT_SEL_*        - result-stream selector codes (u, n, g, lambda)
//   next_sel()       - advances the result selector by one beat
package keygen_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_P,
    LOAD_Q,
    KICK,
    WAIT_DONE,
    RD_ADDR,
    RD_CAP,
    EMIT,
    FINISH
  } keygen_state_e;

  localparam logic [1:0] OUT_SEL_U      = 2'd0;
  localparam logic [1:0] OUT_SEL_N      = 2'd1;
  localparam logic [1:0] OUT_SEL_G      = 2'd2;
  localparam logic [1:0] OUT_SEL_LAMBDA = 2'd3;

  function automatic logic [1:0] next_sel(input logic [1:0] sel);
    return sel + 2'd1;
  endfunction

endpackage

// File: rtl/keygen_sequencer_if.sv
// keygen_sequencer_if
// Bundles the two valid/ready streams of the sequencer.
//   in_valid/in_ready/in_data             - input word stream (p words, then q words)
//   out_valid/out_ready/out_data/out_sel/out_addr - result stream
// Modports:
//   master - the environment side (drives input words, accepts results)
//   slave  - the sequencer side
interface keygen_sequencer_if #(
  parameter int DATA_WIDTH     = 1024,
  parameter int RAM_ADDR_WIDTH = 5
);

  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_WIDTH-1:0]     in_data;

  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_WIDTH-1:0]     out_data;
  logic [1:0]                out_sel;
  logic [RAM_ADDR_WIDTH-1:0] out_addr;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_addr
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_addr
  );

endinterface

// File: rtl/keygen_out_skid.sv
// keygen_out_skid
// Holds the four result words of one address and emits them as four
// valid/ready beats in the order u, n, g, lambda.
//   clock, reset     - rising-edge clock, asynchronous active-low reset
//   load             - capture u/n/g/lambda/addr_in and start emitting
//   u_in..lambda_in  - result words for the current address
//   addr_in          - address reported with every beat
//   out_ready        - downstream ready
//   out_valid, out_data, out_sel, out_addr - result beat
//   last_beat        - the lambda beat is being accepted this cycle
module keygen_out_skid
  import keygen_pkg::*;
#(
  parameter int DATA_WIDTH     = 1024,
  parameter int RAM_ADDR_WIDTH = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load,
  input  logic [DATA_WIDTH-1:0]     u_in,
  input  logic [DATA_WIDTH-1:0]     n_in,
  input  logic [DATA_WIDTH-1:0]     g_in,
  input  logic [DATA_WIDTH-1:0]     lambda_in,
  input  logic [RAM_ADDR_WIDTH-1:0] addr_in,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [1:0]                out_sel,
  output logic [RAM_ADDR_WIDTH-1:0] out_addr,
  output logic                      last_beat
);

  logic [DATA_WIDTH-1:0] hold_u;
  logic [DATA_WIDTH-1:0] hold_n;
  logic [DATA_WIDTH-1:0] hold_g;
  logic [DATA_WIDTH-1:0] hold_lambda;

  // The beat only moves on a handshake, so the held words, selector and
  // address stay frozen for as long as the consumer stalls.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_u      <= '0;
      hold_n      <= '0;
      hold_g      <= '0;
      hold_lambda <= '0;
      out_addr    <= '0;
      out_sel     <= OUT_SEL_U;
      out_valid   <= 1'b0;
    end else if (load) begin
      hold_u      <= u_in;
      hold_n      <= n_in;
      hold_g      <= g_in;
      hold_lambda <= lambda_in;
      out_addr    <= addr_in;
      out_sel     <= OUT_SEL_U;
      out_valid   <= 1'b1;
    end else if (out_valid && out_ready) begin
      if (out_sel == OUT_SEL_LAMBDA) begin
        out_valid <= 1'b0;
      end else begin
        out_sel <= next_sel(out_sel);
      end
    end
  end

  // Data is a mux of registered holds by the registered selector, so it is
  // glitch-free and stable while stalled.
  always_comb begin
    out_data = hold_u;
    case (out_sel)
      OUT_SEL_U:      out_data = hold_u;
      OUT_SEL_N:      out_data = hold_n;
      OUT_SEL_G:      out_data = hold_g;
      OUT_SEL_LAMBDA: out_data = hold_lambda;
      default:        out_data = hold_u;
    endcase
  end

  assign last_beat = out_valid && out_ready && (out_sel == OUT_SEL_LAMBDA);

endmodule

// File: rtl/keygen_sequencer.sv
// keygen_sequencer
// Loads WORDS p words and WORDS q words into the key-generation input RAMs,
// kicks the key generator, waits (with timeout) for it to finish, then
// reads every result address and streams u, n, g, lambda per address.
//   clock, reset   - rising-edge clock, asynchronous active-low reset
//   cmd_start      - begin a job (only honoured in IDLE)
//   busy           - job in progress
//   job_done       - one-cycle completion pulse
//   timeout_err    - sticky: key generator did not finish in time
//   io (slave)     - input word stream and result stream
//   p_*/q_*        - write ports of the p and q input RAMs
//   kg_start       - one-cycle start pulse to the key generator
//   kg_done        - key generator finished
//   out_rd_addr    - read address of the result RAMs (one-cycle latency)
//   u/n/g/lambda_dout - result RAM read data
module keygen_sequencer
  import keygen_pkg::*;
#(
  parameter int DATA_WIDTH     = 1024,
  parameter int RAM_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cmd_start,
  output logic                      busy,
  output logic                      job_done,
  output logic                      timeout_err,
  keygen_sequencer_if.slave         io,
  output logic [DATA_WIDTH-1:0]     p_din,
  output logic [RAM_ADDR_WIDTH-1:0] p_wr_addr,
  output logic                      p_wr_en,
  output logic [DATA_WIDTH-1:0]     q_din,
  output logic [RAM_ADDR_WIDTH-1:0] q_wr_addr,
  output logic                      q_wr_en,
  output logic                      kg_start,
  input  logic                      kg_done,
  output logic [RAM_ADDR_WIDTH-1:0] out_rd_addr,
  input  logic [DATA_WIDTH-1:0]     u_dout,
  input  logic [DATA_WIDTH-1:0]     n_dout,
  input  logic [DATA_WIDTH-1:0]     g_dout,
  input  logic [DATA_WIDTH-1:0]     lambda_dout
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0]         WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RAM_ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [RAM_ADDR_WIDTH-1:0] ADDR_ONE  = RAM_ADDR_WIDTH'(1);
  localparam logic [WAIT_W-1:0]         WAIT_ONE  = WAIT_W'(1);

  keygen_state_e             state;
  logic [RAM_ADDR_WIDTH-1:0] word_cnt;
  logic [RAM_ADDR_WIDTH-1:0] rd_addr;
  logic [WAIT_W-1:0]         wait_cnt;
  logic                      in_ready_r;
  logic                      accept;
  logic                      cap_load;
  logic                      last_beat;

  assign io.in_ready  = in_ready_r;
  assign accept       = io.in_valid && in_ready_r;
  assign out_rd_addr  = rd_addr;
  // Read data for rd_addr arrives one cycle after RD_ADDR, i.e. during RD_CAP.
  assign cap_load     = (state == RD_CAP);

  // Main sequencer. Write enables, kg_start and job_done default low each
  // cycle so they only ever form single-cycle pulses. Counters wrap
  // naturally at WORDS, which leaves them at 0 for the next phase.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      word_cnt    <= '0;
      rd_addr     <= '0;
      wait_cnt    <= '0;
      in_ready_r  <= 1'b0;
      busy        <= 1'b0;
      job_done    <= 1'b0;
      timeout_err <= 1'b0;
      p_din       <= '0;
      p_wr_addr   <= '0;
      p_wr_en     <= 1'b0;
      q_din       <= '0;
      q_wr_addr   <= '0;
      q_wr_en     <= 1'b0;
      kg_start    <= 1'b0;
    end else begin
      p_wr_en  <= 1'b0;
      q_wr_en  <= 1'b0;
      kg_start <= 1'b0;
      job_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_start) begin
            state       <= LOAD_P;
            busy        <= 1'b1;
            in_ready_r  <= 1'b1;
            timeout_err <= 1'b0;
            word_cnt    <= '0;
          end
        end
        LOAD_P: begin
          if (accept) begin
            p_wr_en   <= 1'b1;
            p_din     <= io.in_data;
            p_wr_addr <= word_cnt;
            word_cnt  <= word_cnt + ADDR_ONE;
            if (word_cnt == LAST_ADDR) begin
              state <= LOAD_Q;
            end
          end
        end
        LOAD_Q: begin
          if (accept) begin
            q_wr_en   <= 1'b1;
            q_din     <= io.in_data;
            q_wr_addr <= word_cnt;
            word_cnt  <= word_cnt + ADDR_ONE;
            if (word_cnt == LAST_ADDR) begin
              state      <= KICK;
              in_ready_r <= 1'b0;
            end
          end
        end
        // The last q write is on the RAM port during this cycle.
        KICK: begin
          state    <= WAIT_DONE;
          kg_start <= 1'b1;
          wait_cnt <= '0;
        end
        WAIT_DONE: begin
          if (kg_done) begin
            state   <= RD_ADDR;
            rd_addr <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state       <= IDLE;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_ONE;
          end
        end
        RD_ADDR: state <= RD_CAP;
        RD_CAP:  state <= EMIT;
        EMIT: begin
          if (last_beat) begin
            if (rd_addr == LAST_ADDR) begin
              state    <= FINISH;
              job_done <= 1'b1;
            end else begin
              state   <= RD_ADDR;
              rd_addr <= rd_addr + ADDR_ONE;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          in_ready_r <= 1'b0;
        end
      endcase
    end
  end

  keygen_out_skid #(
    .DATA_WIDTH     (DATA_WIDTH),
    .RAM_ADDR_WIDTH (RAM_ADDR_WIDTH)
  ) u_out_skid (
    .clock     (clock),
    .reset     (reset),
    .load      (cap_load),
    .u_in      (u_dout),
    .n_in      (n_dout),
    .g_in      (g_dout),
    .lambda_in (lambda_dout),
    .addr_in   (rd_addr),
    .out_ready (io.out_ready),
    .out_valid (io.out_valid),
    .out_data  (io.out_data),
    .out_sel   (io.out_sel),
    .out_addr  (io.out_addr),
    .last_beat (last_beat)
  );

endmodule

// File: tb/tb_keygen_sequencer.sv
// tb_keygen_sequencer
// Table-driven bench for keygen_sequencer (32-bit words, 32 addresses,
// 100-cycle timeout). Each table row is one job: key-generator delay
// (0 = never finishes), out_ready pattern, spurious-pulse injection, and
// the expected beat count / job_done / timeout_err. A reset-during-load
// sequence is written out by hand. A negedge monitor checks every RAM
// write, stall stability and records the result beats.
module tb_keygen_sequencer;

  localparam int DW      = 32;
  localparam int AW      = 5;
  localparam int WORDS   = 2**AW;
  localparam int TIMEOUT = 100;
  localparam int BEATS   = 4 * WORDS;

  typedef struct {
    int kg_delay;
    int ready_mode;
    bit spur;
    int exp_beats;
    int exp_done;
    bit exp_timeout;
  } job_vec_t;

  logic          clock;
  logic          reset;
  logic          cmd_start;
  logic          busy;
  logic          job_done;
  logic          timeout_err;
  logic [DW-1:0] p_din;
  logic [AW-1:0] p_wr_addr;
  logic          p_wr_en;
  logic [DW-1:0] q_din;
  logic [AW-1:0] q_wr_addr;
  logic          q_wr_en;
  logic          kg_start;
  logic          kg_done;
  logic [AW-1:0] out_rd_addr;
  logic [DW-1:0] u_dout;
  logic [DW-1:0] n_dout;
  logic [DW-1:0] g_dout;
  logic [DW-1:0] lambda_dout;

  keygen_sequencer_if #(.DATA_WIDTH(DW), .RAM_ADDR_WIDTH(AW)) io ();

  keygen_sequencer #(
    .DATA_WIDTH     (DW),
    .RAM_ADDR_WIDTH (AW),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_start   (cmd_start),
    .busy        (busy),
    .job_done    (job_done),
    .timeout_err (timeout_err),
    .io          (io),
    .p_din       (p_din),
    .p_wr_addr   (p_wr_addr),
    .p_wr_en     (p_wr_en),
    .q_din       (q_din),
    .q_wr_addr   (q_wr_addr),
    .q_wr_en     (q_wr_en),
    .kg_start    (kg_start),
    .kg_done     (kg_done),
    .out_rd_addr (out_rd_addr),
    .u_dout      (u_dout),
    .n_dout      (n_dout),
    .g_dout      (g_dout),
    .lambda_dout (lambda_dout)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int job_id = 0;
  int ready_mode = 0;

  // Monitor-owned bookkeeping, cleared whenever job_id changes.
  int  mon_job = 0;
  int  p_cnt, q_cnt, kg_cycles, done_cycles, beat_cnt, to_lat, wait_n;
  bit  counting, stall_prev;
  logic [DW-1:0] st_data;
  logic [1:0]    st_sel;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] beat_data [BEATS];
  logic [1:0]    beat_sel  [BEATS];
  logic [AW-1:0] beat_addr [BEATS];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Synchronous-read result RAM model: address sampled in one cycle,
  // data valid in the next.
  initial begin
    logic [AW-1:0] a;
    u_dout = '0; n_dout = '0; g_dout = '0; lambda_dout = '0;
    forever begin
      @(negedge clock);
      a = out_rd_addr;
      @(posedge clock);
      #1;
      u_dout      = 32'h1000 + DW'(a);
      n_dout      = 32'h2000 + DW'(a);
      g_dout      = 32'h3000 + DW'(a);
      lambda_dout = 32'h4000 + DW'(a);
    end
  end

  // out_ready driver: 0 = always ready, 1 = random, otherwise not ready.
  initial begin
    io.out_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (ready_mode == 1) io.out_ready = ($urandom_range(0, 1) == 1);
      else                 io.out_ready = (ready_mode == 0);
    end
  end

  always @(negedge clock) begin
    if (mon_job != job_id) begin
      mon_job = job_id;
      p_cnt = 0; q_cnt = 0; kg_cycles = 0; done_cycles = 0; beat_cnt = 0;
      to_lat = -1; wait_n = 0; counting = 0; stall_prev = 0;
    end
    if (p_wr_en) begin
      check_output("p_write", 64'({p_wr_addr, p_din}), 64'({AW'(p_cnt), DW'(p_cnt)}));
      p_cnt++;
    end
    if (q_wr_en) begin
      check_output("q_write", 64'({q_wr_addr, q_din}),
                   64'({AW'(q_cnt), DW'(32'h100 + q_cnt)}));
      q_cnt++;
    end
    if (kg_start) begin
      kg_cycles++;
      counting = 1;
      wait_n   = 0;
    end else if (counting) begin
      wait_n++;
      if (timeout_err) begin
        to_lat   = wait_n;
        counting = 0;
      end
      if (kg_done) counting = 0;
    end
    if (job_done) done_cycles++;
    if (stall_prev) begin
      check_output("stall_hold", 64'({io.out_valid, io.out_sel, io.out_addr, io.out_data}),
                   64'({1'b1, st_sel, st_addr, st_data}));
    end
    stall_prev = io.out_valid && !io.out_ready;
    st_data = io.out_data;
    st_sel  = io.out_sel;
    st_addr = io.out_addr;
    if (io.out_valid && io.out_ready) begin
      if (beat_cnt < BEATS) begin
        beat_data[beat_cnt] = io.out_data;
        beat_sel[beat_cnt]  = io.out_sel;
        beat_addr[beat_cnt] = io.out_addr;
      end
      beat_cnt++;
    end
  end

  task automatic pulse_cmd_start();
    @(posedge clock); #1 cmd_start = 1'b1;
    @(posedge clock); #1 cmd_start = 1'b0;
  endtask

  // Presents n words (p = index, q = 0x100+index) with in_valid held high;
  // a word advances only after a cycle in which in_ready was high.
  task automatic feed_words(input int n);
    bit rdy;
    int guard;
    for (int k = 0; k < n; k++) begin
      io.in_valid = 1'b1;
      io.in_data  = (k < WORDS) ? DW'(k) : DW'(32'h100 + (k - WORDS));
      guard = 0;
      do begin
        @(negedge clock);
        rdy = io.in_ready;
        @(posedge clock);
        #1;
        guard++;
      end while (!rdy && guard < 1000);
      if (!rdy) begin
        check_output("feed_bound", 64'(k), 64'(n));
        break;
      end
    end
    io.in_valid = 1'b0;
  endtask

  task automatic kg_model(input int delay);
    int n = 0;
    while (!kg_start && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (!kg_start) begin
      check_output("kg_start_bound", 64'(kg_start), 64'd1);
    end else begin
      repeat (delay) @(posedge clock);
      #1 kg_done = 1'b1;
      @(posedge clock);
      #1 kg_done = 1'b0;
    end
  endtask

  task automatic spur_pulse();
    int n = 0;
    while (!(io.out_valid && beat_cnt >= 10) && n < 5000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 5000) begin
      check_output("spur_bound", 64'(beat_cnt), 64'd10);
    end else begin
      cmd_start = 1'b1;
      kg_done   = 1'b1;
      @(negedge clock);
      cmd_start = 1'b0;
      kg_done   = 1'b0;
    end
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (busy && n < max_cycles);
    if (busy) check_output("job_end_bound", 64'(busy), 64'd0);
  endtask

  task automatic apply_stimulus(input job_vec_t v);
    job_id++;
    ready_mode  = v.ready_mode;
    io.in_valid = 1'b1;
    io.in_data  = '0;
    pulse_cmd_start();
    check_output("start_busy", 64'(busy), 64'd1);
    check_output("start_err_clear", 64'(timeout_err), 64'd0);
    fork
      feed_words(2 * WORDS);
      if (v.kg_delay > 0) kg_model(v.kg_delay);
      if (v.spur) spur_pulse();
      wait_idle(5000);
    join
    repeat (2) @(negedge clock);
  endtask

  task automatic check_job(input job_vec_t v, input int idx);
    check_output($sformatf("job%0d_p_writes", idx), 64'(p_cnt), 64'(WORDS));
    check_output($sformatf("job%0d_q_writes", idx), 64'(q_cnt), 64'(WORDS));
    check_output($sformatf("job%0d_kg_start_cycles", idx), 64'(kg_cycles), 64'd1);
    check_output($sformatf("job%0d_beats", idx), 64'(beat_cnt), 64'(v.exp_beats));
    check_output($sformatf("job%0d_job_done", idx), 64'(done_cycles), 64'(v.exp_done));
    check_output($sformatf("job%0d_timeout_err", idx), 64'(timeout_err), 64'(v.exp_timeout));
    check_output($sformatf("job%0d_idle", idx), 64'({busy, io.in_ready, io.out_valid}), 64'd0);
    if (v.exp_timeout)
      check_output($sformatf("job%0d_timeout_cycle", idx), 64'(to_lat), 64'(TIMEOUT));
    if (v.exp_beats == BEATS) begin
      for (int i = 0; i < BEATS; i++) begin
        check_output($sformatf("job%0d_beat%0d", idx, i),
                     64'({beat_addr[i], beat_sel[i], beat_data[i]}),
                     64'({AW'(i / 4), 2'(i % 4), DW'(32'h1000 * ((i % 4) + 1) + (i / 4))}));
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    check_output({name, "_ctl"},
                 64'({busy, job_done, timeout_err, io.in_ready, p_wr_en, q_wr_en, kg_start,
                      io.out_valid, p_wr_addr, q_wr_addr, out_rd_addr, io.out_sel, io.out_addr}),
                 64'd0);
    check_output({name, "_pdin"}, 64'(p_din), 64'd0);
    check_output({name, "_qdin"}, 64'(q_din), 64'd0);
    check_output({name, "_odata"}, 64'(io.out_data), 64'd0);
  endtask

  job_vec_t vecs [5];

  initial begin
    vecs[0] = '{kg_delay: 50, ready_mode: 0, spur: 0, exp_beats: BEATS, exp_done: 1, exp_timeout: 0};
    vecs[1] = '{kg_delay: 50, ready_mode: 1, spur: 0, exp_beats: BEATS, exp_done: 1, exp_timeout: 0};
    vecs[2] = '{kg_delay: 0,  ready_mode: 0, spur: 0, exp_beats: 0,     exp_done: 0, exp_timeout: 1};
    vecs[3] = '{kg_delay: 50, ready_mode: 0, spur: 1, exp_beats: BEATS, exp_done: 1, exp_timeout: 0};
    vecs[4] = '{kg_delay: 3,  ready_mode: 1, spur: 1, exp_beats: BEATS, exp_done: 1, exp_timeout: 0};

    reset       = 1'b0;
    cmd_start   = 1'b0;
    kg_done     = 1'b0;
    io.in_valid = 1'b0;
    io.in_data  = '0;

    repeat (3) @(negedge clock);
    check_all_zero("reset_state");
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_output("idle_after_reset", 64'({busy, io.in_ready}), 64'd0);

    for (int i = 0; i < 5; i++) begin
      $display("[TB] job %0d: kg_delay=%0d ready_mode=%0d spur=%0d",
               i, vecs[i].kg_delay, vecs[i].ready_mode, vecs[i].spur);
      apply_stimulus(vecs[i]);
      check_job(vecs[i], i);
    end

    // Reset while q word 10 is being presented, then a fresh full job.
    $display("[TB] reset during LOAD_Q");
    job_id++;
    ready_mode = 0;
    pulse_cmd_start();
    feed_words(WORDS + 10);
    io.in_valid = 1'b1;
    io.in_data  = 32'h10A;
    check_output("preload_q_count", 64'(q_wr_en), 64'd1);
    @(negedge clock);
    #2 reset = 1'b0;
    #1 check_all_zero("async_reset");
    io.in_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_output("no_resume", 64'({busy, io.in_ready, p_wr_en, q_wr_en}), 64'd0);
    apply_stimulus(vecs[0]);
    check_job(vecs[0], 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
